// File: rtl/fpdiv_pkg.sv
// Shared definitions for the floating-point divider arbiter and its helpers.
package fpdiv_pkg;

   localparam int FP_W = 32;

   // Bit positions inside the 3-bit flag field {exception, overflow, underflow}
   localparam int FLG_EXC = 2;
   localparam int FLG_OVF = 1;
   localparam int FLG_UNF = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted index and wraps, so a steadily requesting input is never starved.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   int   cand;
   logic found;

   // First asserted request at or after last+1, modulo N
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(last) + k) % N;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/fpdiv_arbiter.sv
// Shares one combinational single-precision divider among NREQ requesters.
// The winner's operands are registered onto div_a/div_b and held for LAT
// cycles, then quotient and flags are captured and returned to the winner.
// Optional: FPDIV_ARB_EXC_STICKY_EN enables per-requester sticky exception bits.
//
// state | meaning
// IDLE  | arbitrating, req_ready shows the round-robin winner
// BUSY  | operands held on the divider, cnt counts down the window
// DONE  | result held, rsp_valid to the granted requester until handshake
module fpdiv_arbiter
   import fpdiv_pkg::*;
#(
   parameter  int NREQ = 2,
   parameter  int LAT  = 3,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*FP_W-1:0] req_a,
   input  logic [NREQ*FP_W-1:0] req_b,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [FP_W-1:0]      rsp_result,
   output logic [2:0]           rsp_flags,
   output logic [FP_W-1:0]      div_a,
   output logic [FP_W-1:0]      div_b,
   input  logic [FP_W-1:0]      div_opt,
   input  logic                 div_ovf,
   input  logic                 div_unf,
   input  logic                 div_exc,
   output logic [NREQ-1:0]      exc_sticky,
   input  logic [NREQ-1:0]      exc_clr
);

   localparam int CW = 4;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   grant_q;
   logic [IW-1:0]   last_q;
   logic [NREQ-1:0] arb_grant;
   logic [IW-1:0]   arb_idx;
   logic            accept;
   logic            capture;
   logic            rsp_done;

   rr_arbiter #(.N(NREQ)) u_rr (
      .req   (req_valid),
      .last  (last_q),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   // The arbiter only grants asserted requests, so any grant in IDLE is an accept
   assign accept   = (state == IDLE) && (|arb_grant);
   assign capture  = (state == BUSY) && (cnt == '0);
   assign rsp_done = (state == DONE) && rsp_ready[grant_q];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)   state_nxt = BUSY;
         BUSY:    if (capture)  state_nxt = DONE;
         DONE:    if (rsp_done) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      case (state)
         IDLE:    req_ready = arb_grant;
         DONE:    rsp_valid = NREQ'(1) << grant_q;
         default: ;
      endcase
   end

   // Operand latch, window counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_a      <= '0;
         div_b      <= '0;
         grant_q    <= '0;
         last_q     <= IW'(NREQ - 1);
         cnt        <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else if (accept) begin
         div_a   <= req_a[arb_idx*FP_W +: FP_W];
         div_b   <= req_b[arb_idx*FP_W +: FP_W];
         grant_q <= arb_idx;
         last_q  <= arb_idx;
         cnt     <= CW'(LAT - 1);
      end else if (capture) begin
         rsp_result         <= div_opt;
         rsp_flags[FLG_EXC] <= div_exc;
         rsp_flags[FLG_OVF] <= div_ovf;
         rsp_flags[FLG_UNF] <= div_unf;
      end else if (state == BUSY) begin
         cnt <= cnt - CW'(1);
      end
   end

`ifdef FPDIV_ARB_EXC_STICKY_EN
   logic [NREQ-1:0] sticky_q;

   // Sticky exception per requester; a set in the same cycle beats a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (capture && div_exc && (grant_q == IW'(i))) sticky_q[i] <= 1'b1;
            else if (exc_clr[i])                             sticky_q[i] <= 1'b0;
         end
      end
   end

   assign exc_sticky = sticky_q;
`else
   logic unused_exc_clr;
   assign unused_exc_clr = ^exc_clr;
   assign exc_sticky     = '0;
`endif

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Directed bench for fpdiv_arbiter: one LAT=3 instance for the main sequence
// and one LAT=1 instance for the short-window timing.
module tb_fpdiv_arbiter;

   localparam int NREQ = 2;
   localparam int LAT  = 3;

`ifdef FPDIV_ARB_EXC_STICKY_EN
   localparam logic [1:0] STICKY_EXP = 2'b01;
`else
   localparam logic [1:0] STICKY_EXP = 2'b00;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, exc_sticky, exc_clr;
   logic [NREQ*32-1:0] req_a, req_b;
   logic [31:0]        rsp_result, div_a, div_b, div_opt;
   logic [2:0]         rsp_flags;
   logic               div_ovf, div_unf, div_exc;

   logic [NREQ-1:0]    l1_req_valid, l1_req_ready, l1_rsp_valid, l1_rsp_ready, l1_exc_sticky, l1_exc_clr;
   logic [NREQ*32-1:0] l1_req_a, l1_req_b;
   logic [31:0]        l1_rsp_result, l1_div_a, l1_div_b, l1_div_opt;
   logic [2:0]         l1_rsp_flags;
   logic               l1_div_ovf, l1_div_unf, l1_div_exc;

   int ntests = 0;
   int nfail  = 0;

   // Behavioural divider: hand-computed IEEE single results for the vectors used
   function automatic logic [34:0] div_model(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h40C00000, 32'h40000000}: return {3'b000, 32'h40400000}; // 6/2
         {32'h41200000, 32'h40800000}: return {3'b000, 32'h40200000}; // 10/4
         {32'h3F800000, 32'h40800000}: return {3'b000, 32'h3E800000}; // 1/4
         {32'h41000000, 32'h40000000}: return {3'b000, 32'h40800000}; // 8/2
         {32'h7F000000, 32'h00800000}: return {3'b010, 32'h7F800000}; // overflow
         default: begin
            if (b == 32'h0) return {3'b100, 32'h7F800000};
            else            return '0;
         end
      endcase
   endfunction

   assign {div_exc, div_ovf, div_unf, div_opt}             = div_model(div_a, div_b);
   assign {l1_div_exc, l1_div_ovf, l1_div_unf, l1_div_opt} = div_model(l1_div_a, l1_div_b);

   fpdiv_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .div_a(div_a), .div_b(div_b), .div_opt(div_opt),
      .div_ovf(div_ovf), .div_unf(div_unf), .div_exc(div_exc),
      .exc_sticky(exc_sticky), .exc_clr(exc_clr)
   );

   fpdiv_arbiter #(.NREQ(NREQ), .LAT(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_a(l1_req_a), .req_b(l1_req_b),
      .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_result(l1_rsp_result), .rsp_flags(l1_rsp_flags),
      .div_a(l1_div_a), .div_b(l1_div_b), .div_opt(l1_div_opt),
      .div_ovf(l1_div_ovf), .div_unf(l1_div_unf), .div_exc(l1_div_exc),
      .exc_sticky(l1_exc_sticky), .exc_clr(l1_exc_clr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counts edges from the accept edge until rsp_valid rises, bounded at 20
   task automatic wait_rsp(output int c);
      c = 0;
      while (rsp_valid == '0 && c < 20) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic wait_rsp_l1(output int c);
      c = 0;
      while (l1_rsp_valid == '0 && c < 20) begin
         @(negedge clk);
         c++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         c;
      logic       seen;
      logic [1:0] exp_g;

      rst_n = 1'b0;
      req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; exc_clr = '0;
      l1_req_valid = '0; l1_rsp_ready = '0; l1_req_a = '0; l1_req_b = '0; l1_exc_clr = '0;

      // Reset state
      #2;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_div_a", div_a, 32'h0);
      chk("rst_rsp_result", rsp_result, 32'h0);
      chk("rst_rsp_flags", rsp_flags, 3'b000);
      chk("rst_exc_sticky", exc_sticky, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // Single operation from requester 0: 6/2
      @(negedge clk);
      req_valid = 2'b01; req_a[31:0] = 32'h40C00000; req_b[31:0] = 32'h40000000; rsp_ready = 2'b11;
      #1 chk("t1_req_ready", req_ready, 2'b01);
      @(negedge clk);
      chk("t1_div_a", div_a, 32'h40C00000);
      chk("t1_div_b", div_b, 32'h40000000);
      chk("t1_ready_busy", req_ready, 2'b00);
      req_valid = 2'b00;
      wait_rsp(c);
      chk("t1_latency", c, LAT);
      chk("t1_rsp_valid", rsp_valid, 2'b01);
      chk("t1_result", rsp_result, 32'h40400000);
      chk("t1_flags", rsp_flags, 3'b000);
      @(negedge clk);
      chk("t1_rsp_dropped", rsp_valid, 2'b00);

      // Reset pulsed while BUSY with cnt==1
      req_valid = 2'b01; req_a[31:0] = 32'h41000000; req_b[31:0] = 32'h40000000;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr_div_a", div_a, 32'h0);
      chk("mr_div_b", div_b, 32'h0);
      chk("mr_result", rsp_result, 32'h0);
      chk("mr_rsp_valid", rsp_valid, 2'b00);
      chk("mr_req_ready", req_ready, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | (|rsp_valid);
      end
      chk("mr_no_response", seen, 1'b0);

      // Round robin: both requesters continuously valid, order 0,1,0,1
      req_a = {32'h3F800000, 32'h41200000};
      req_b = {32'h40800000, 32'h40800000};
      req_valid = 2'b11;
      for (int op = 0; op < 4; op++) begin
         exp_g = (op % 2 == 0) ? 2'b01 : 2'b10;
         #1 chk("rr_req_ready", req_ready, exp_g);
         @(negedge clk);
         wait_rsp(c);
         chk("rr_latency", c, LAT);
         chk("rr_rsp_valid", rsp_valid, exp_g);
         chk("rr_result", rsp_result, (op % 2 == 0) ? 32'h40200000 : 32'h3E800000);
         @(negedge clk);
      end
      req_valid = 2'b00;

      // Divide by zero: exception flag and sticky behaviour
      req_valid = 2'b01; req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h0;
      @(negedge clk);
      req_valid = 2'b00;
      wait_rsp(c);
      chk("dz_flags", rsp_flags, 3'b100);
      chk("dz_result", rsp_result, 32'h7F800000);
      chk("dz_sticky", exc_sticky, STICKY_EXP);
      @(negedge clk);
      chk("dz_sticky_held", exc_sticky, STICKY_EXP);
      exc_clr = 2'b01;
      @(negedge clk);
      exc_clr = 2'b00;
      chk("dz_sticky_clr", exc_sticky, 2'b00);

      // Overflow from requester 1
      req_valid = 2'b10; req_a[63:32] = 32'h7F000000; req_b[63:32] = 32'h00800000;
      @(negedge clk);
      req_valid = 2'b00;
      wait_rsp(c);
      chk("ov_rsp_valid", rsp_valid, 2'b10);
      chk("ov_flags", rsp_flags, 3'b010);
      chk("ov_sticky", exc_sticky, 2'b00);
      @(negedge clk);

      // Backpressure in DONE; rsp_ready of the other requester is ignored
      req_valid = 2'b01; req_a[31:0] = 32'h41000000; req_b[31:0] = 32'h40000000; rsp_ready = 2'b10;
      @(negedge clk);
      req_valid = 2'b11;
      wait_rsp(c);
      chk("hold_latency", c, LAT);
      repeat (5) begin
         chk("hold_rsp_valid", rsp_valid, 2'b01);
         chk("hold_result", rsp_result, 32'h40800000);
         chk("hold_flags", rsp_flags, 3'b000);
         chk("hold_req_ready", req_ready, 2'b00);
         @(negedge clk);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      chk("hold_next_grant", req_ready, 2'b10);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      @(negedge clk);

      // LAT=1 instance: one-cycle window, one operation per 3 cycles
      l1_rsp_ready = 2'b11;
      l1_req_valid = 2'b01; l1_req_a[31:0] = 32'h40C00000; l1_req_b[31:0] = 32'h40000000;
      for (int op = 0; op < 3; op++) begin
         #1 chk("l1_req_ready", l1_req_ready, 2'b01);
         @(negedge clk);
         wait_rsp_l1(c);
         chk("l1_latency", c, 1);
         chk("l1_result", l1_rsp_result, 32'h40400000);
         chk("l1_flags", l1_rsp_flags, 3'b000);
         @(negedge clk);
      end
      l1_req_valid = 2'b00;
      chk("l1_sticky", l1_exc_sticky, 2'b00);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
